// File: rtl/output_serializer_pkg.sv
// Shared pixel-sensor configuration.
//   DefRowPixels / DefBusPixels / DefPixelBits : default geometry for the serializer
//   pixel_t       : one pixel word at the default pixel width
//   occ_e         : ping-pong occupancy (number of banks holding a row)
//   beat_cnt_width: width of a counter over 'beats' values, never below 1
package PixelSensorConfig;

  localparam int unsigned DefRowPixels = 8;
  localparam int unsigned DefBusPixels = 2;
  localparam int unsigned DefPixelBits = 8;

  typedef logic [DefPixelBits-1:0] pixel_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } occ_e;

  function automatic int unsigned beat_cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/output_serializer_row_bank.sv
// One row store of the ping-pong pair.
//   CLK      : clock
//   WE       : load WDATA into the store at the rising edge
//   WDATA    : full row, pixel i in bits [i*PIXEL_BITS +: PIXEL_BITS]
//   BEAT_SEL : logical beat number (0 = first beat emitted)
//   RDATA    : selected beat; REVERSE maps logical beat k to physical beat BEATS-1-k
// Contents are deliberately not reset; occupancy in the parent decides validity.
module row_bank #(
  parameter int unsigned ROW_PIXELS = 8,
  parameter int unsigned BUS_PIXELS = 2,
  parameter int unsigned PIXEL_BITS = 8,
  parameter int unsigned REVERSE    = 0,
  parameter int unsigned BEAT_W     = 2
) (
  input  logic                             CLK,
  input  logic                             WE,
  input  logic [ROW_PIXELS*PIXEL_BITS-1:0] WDATA,
  input  logic [BEAT_W-1:0]                BEAT_SEL,
  output logic [BUS_PIXELS*PIXEL_BITS-1:0] RDATA
);

  localparam int unsigned BEATS     = ROW_PIXELS / BUS_PIXELS;
  localparam int unsigned BEAT_BITS = BUS_PIXELS * PIXEL_BITS;

  logic [ROW_PIXELS*PIXEL_BITS-1:0] row_q;
  logic [BEAT_W-1:0]                phys_sel;

  always_ff @(posedge CLK) begin
    if (WE) begin
      row_q <= WDATA;
    end
  end

  always_comb begin
    phys_sel = (REVERSE != 0) ? (BEAT_W'(BEATS - 1) - BEAT_SEL) : BEAT_SEL;
    RDATA    = '0;
    // Constant part-selects keep the mux free of variable-index arithmetic.
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (phys_sel == BEAT_W'(b)) begin
        RDATA = row_q[b*BEAT_BITS +: BEAT_BITS];
      end
    end
  end

endmodule

// File: rtl/output_serializer.sv
// Row-to-beat serializer with two ping-pong row banks.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   ROW_VALID / ROW_READY / ROW_DATA : upstream row handshake (one full row per transfer)
//   OUT_VALID / OUT_READY / OUT_DATA / OUT_LAST : downstream beat handshake
//   OVERFLOW  : sticky, set when a row is offered with both banks full
//   CLEAR_OVF : synchronous clear of OVERFLOW (a coincident set wins)
module output_serializer
  import PixelSensorConfig::*;
#(
  parameter int unsigned ROW_PIXELS = DefRowPixels,
  parameter int unsigned BUS_PIXELS = DefBusPixels,
  parameter int unsigned PIXEL_BITS = DefPixelBits,
  parameter int unsigned REVERSE    = 0
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic                             ROW_VALID,
  input  logic [ROW_PIXELS*PIXEL_BITS-1:0] ROW_DATA,
  output logic                             ROW_READY,
  output logic                             OUT_VALID,
  input  logic                             OUT_READY,
  output logic [BUS_PIXELS*PIXEL_BITS-1:0] OUT_DATA,
  output logic                             OUT_LAST,
  output logic                             OVERFLOW,
  input  logic                             CLEAR_OVF
);

  localparam int unsigned BEATS  = ROW_PIXELS / BUS_PIXELS;
  localparam int unsigned BEAT_W = beat_cnt_width(BEATS);

  if ((BUS_PIXELS == 0) || (ROW_PIXELS % BUS_PIXELS != 0)) begin : g_bad_cfg
    $error("output_serializer: ROW_PIXELS must be a multiple of BUS_PIXELS");
  end

  occ_e              occ_q;
  logic              wp_q;
  logic              rp_q;
  logic [BEAT_W-1:0] beat_q;
  logic              ovf_q;

  logic              row_acc;
  logic              beat_fire;
  logic              last_beat;
  logic              row_done;
  logic [BUS_PIXELS*PIXEL_BITS-1:0] rdata0;
  logic [BUS_PIXELS*PIXEL_BITS-1:0] rdata1;

  // ROW_READY is held low while reset is asserted, not just after it.
  assign ROW_READY = RESET_N && (occ_q != StFull);
  assign OUT_VALID = (occ_q != StEmpty);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign OUT_LAST  = OUT_VALID && last_beat;
  assign OVERFLOW  = ovf_q;

  assign row_acc   = ROW_VALID && ROW_READY;
  assign beat_fire = OUT_VALID && OUT_READY;
  assign row_done  = beat_fire && last_beat;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      occ_q  <= StEmpty;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      beat_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (row_acc) begin
        wp_q <= ~wp_q;
      end

      if (beat_fire) begin
        if (last_beat) begin
          beat_q <= '0;
          rp_q   <= ~rp_q;
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end

      // Accept and row completion together leave occupancy unchanged.
      case ({row_acc, row_done})
        2'b10:   occ_q <= (occ_q == StEmpty) ? StHalf : StFull;
        2'b01:   occ_q <= (occ_q == StFull) ? StHalf : StEmpty;
        default: occ_q <= occ_q;
      endcase

      if (ROW_VALID && (occ_q == StFull)) begin
        ovf_q <= 1'b1;
      end else if (CLEAR_OVF) begin
        ovf_q <= 1'b0;
      end
    end
  end

  row_bank #(
    .ROW_PIXELS (ROW_PIXELS),
    .BUS_PIXELS (BUS_PIXELS),
    .PIXEL_BITS (PIXEL_BITS),
    .REVERSE    (REVERSE),
    .BEAT_W     (BEAT_W)
  ) u_bank0 (
    .CLK      (CLK),
    .WE       (row_acc && !wp_q),
    .WDATA    (ROW_DATA),
    .BEAT_SEL (beat_q),
    .RDATA    (rdata0)
  );

  row_bank #(
    .ROW_PIXELS (ROW_PIXELS),
    .BUS_PIXELS (BUS_PIXELS),
    .PIXEL_BITS (PIXEL_BITS),
    .REVERSE    (REVERSE),
    .BEAT_W     (BEAT_W)
  ) u_bank1 (
    .CLK      (CLK),
    .WE       (row_acc && wp_q),
    .WDATA    (ROW_DATA),
    .BEAT_SEL (beat_q),
    .RDATA    (rdata1)
  );

  assign OUT_DATA = !OUT_VALID ? '0 : (rp_q ? rdata1 : rdata0);

endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 Parameter ROW_PIXELS, default 8, pixels per input row; SHALL be an integer multiple of BUS_PIXELS (elaboration error otherwise).
REQ-002 Parameter BUS_PIXELS, default 2, pixels per output beat.
REQ-003 Parameter PIXEL_BITS, default 8, bits per pixel.
REQ-004 Parameter REVERSE, default 0, beat order: 0 = pixel 0 first, 1 = pixel ROW_PIXELS-1 first.
REQ-005 Derived BEATS = ROW_PIXELS/BUS_PIXELS; beat counter width = max(1, clog2(BEATS)).
REQ-006 CLK  input  1  sole clock; all state updates on rising edge.
REQ-007 RESET_N  input  1  asynchronous, active-low reset.
REQ-008 ROW_VALID  input  1  upstream presents a complete row.
REQ-009 ROW_DATA  input  ROW_PIXELS*PIXEL_BITS  row; pixel i in bits [i*PIXEL_BITS +: PIXEL_BITS].
REQ-010 ROW_READY  output  1  a free bank exists.
REQ-011 OUT_VALID  output  1  OUT_DATA holds a valid beat.
REQ-012 OUT_READY  input  1  downstream accepts the beat.
REQ-013 OUT_DATA  output  BUS_PIXELS*PIXEL_BITS  beat; lowest-index pixel of the beat in the low bits.
REQ-014 OUT_LAST  output  1  current beat is the final beat of a row.
REQ-015 OVERFLOW  output  1  sticky flag: a row was offered while no bank was free.
REQ-016 CLEAR_OVF  input  1  synchronous clear of OVERFLOW.

Function
REQ-017 Two row banks (ping-pong), write pointer WP, read pointer RP and occupancy CNT in 0..2 SHALL be maintained; states EMPTY (CNT=0), HALF (CNT=1), FULL (CNT=2).
REQ-018 ROW_READY SHALL be 1 when CNT<2, combinationally, with no dependence on ROW_VALID.
REQ-019 Row accept: ROW_VALID&ROW_READY at an edge SHALL store ROW_DATA into bank WP, toggle WP, and increment CNT.
REQ-020 OUT_VALID SHALL be 1 when CNT>0; a row accepted at edge N SHALL give OUT_VALID=1 with beat 0 on OUT_DATA in the cycle after edge N.
REQ-021 Beat k of bank RP SHALL carry pixels k*BUS_PIXELS..k*BUS_PIXELS+BUS_PIXELS-1 when REVERSE=0, and beat BEATS-1-k when REVERSE=1.
REQ-022 Beat handshake: OUT_VALID&OUT_READY at an edge SHALL advance the beat counter; OUT_DATA and OUT_LAST SHALL stay stable while OUT_VALID&~OUT_READY.
REQ-023 OUT_LAST SHALL be 1 exactly while the beat counter equals BEATS-1 and OUT_VALID=1.
REQ-024 Handshake on the last beat SHALL wrap the beat counter to 0, toggle RP and decrement CNT; when CNT was 2, the next row's beat 0 SHALL be presented in the following cycle with no gap.
REQ-025 Row accept and last-beat handshake at the same edge SHALL leave CNT unchanged and update both pointers.
REQ-026 BEATS=1 SHALL be supported: every beat has OUT_LAST=1.
REQ-027 OUT_DATA SHALL be 0 whenever OUT_VALID=0.
REQ-028 ROW_VALID=1 while CNT=2 SHALL set OVERFLOW at that edge; the row is neither stored nor corrupts banked data.
REQ-029 CLEAR_OVF SHALL clear OVERFLOW at the next edge; when set and clear coincide, set SHALL win.

Reset
REQ-030 RESET_N low SHALL immediately force CNT=0, WP=RP=0, beat counter=0, OVERFLOW=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, ROW_READY=0; bank contents need not be cleared.
REQ-031 Reset mid-row SHALL discard both banks; ROW_READY SHALL be 1 from the first cycle after RESET_N rises.

Structure
REQ-032 Default values for ROW_PIXELS, BUS_PIXELS and PIXEL_BITS SHALL come from the shared PixelSensorConfig package, as SHALL a typedef for a pixel word.
REQ-033 One sub-module, row_bank (a registered row store with a write enable and a beat-select read mux honouring REVERSE), SHALL be instantiated twice.

Verification
REQ-034 Defaults, one row with pixels 0x10..0x17, OUT_READY=1 -> beats {0x11,0x10},{0x13,0x12},{0x15,0x14},{0x17,0x16} on 4 consecutive cycles, OUT_LAST on the 4th only.
REQ-035 Three rows offered back-to-back with OUT_READY=0 -> first two accepted, ROW_READY=0 thereafter, OVERFLOW=1, rows 1 and 2 later emitted intact over 8 beats with no gap.
REQ-036 OUT_READY toggling 1,0,1,0 -> each beat held stable while stalled, no beat duplicated or skipped.
REQ-037 REVERSE=1, same row as REQ-034 -> first beat {0x17,0x16}, last beat {0x11,0x10}.
REQ-038 RESET_N pulsed low after beat 2 -> OUT_VALID=0 immediately, CNT=0, the next accepted row starts at beat 0.
REQ-039 OVERFLOW set and CLEAR_OVF asserted at the same edge -> OVERFLOW stays 1; CLEAR_OVF alone -> 0.
